sram_responder: RTL

// - Memory-side responder for the SLC-3 control unit's Mem_OE/Mem_WE strobes; runs one async-SRAM word cycle per request.
// - Sits between the datapath (MAR address, MDR write data) and the board SRAM; returns read data and a one-cycle Mem_Rdy.
// - Owns all SRAM pin timing, so the controller only holds a strobe until Mem_Rdy.

---
 rtl/sram_resp_pkg.sv | 41 ++++
 rtl/sram_wait_ctr.sv | 35 +++
 rtl/sram_responder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the SLC-3 async-SRAM responder.
// Optional error reporting is enabled by defining SRAM_RESP_ERR_EN.
package sram_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACC,
        RD_RDY,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RELEASE
    } sram_resp_state_t;

    localparam int unsigned RD_WAIT_DEF = 2;
    localparam int unsigned WR_WAIT_DEF = 2;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
        logic dq_oe;
    } sram_pins_t;

    // Pin bundle with every SRAM control deasserted and the pad released.
    localparam sram_pins_t PINS_INACTIVE = '{
        ce_n:  1'b1,
        oe_n:  1'b1,
        we_n:  1'b1,
        ub_n:  1'b1,
        lb_n:  1'b1,
        dq_oe: 1'b0
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_wait_ctr.sv
// Down-counter timing the SRAM access phases; loads on phase entry, stops at 1.
// Used by sram_responder; no configuration macros.
module sram_wait_ctr #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last_c
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q > W'(1))) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_c = (cnt_q == W'(1));

endmodule

// File: rtl/sram_responder.sv
// Runs one async-SRAM word cycle per Mem_OE/Mem_WE request and pulses Mem_Rdy.
// Define SRAM_RESP_ERR_EN to add the sticky Mem_Err protocol-error output.
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RD_WAIT = RD_WAIT_DEF,
    parameter int unsigned WR_WAIT = WR_WAIT_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_from_CPU,
    output logic [DATA_W-1:0] Data_to_CPU,
    output logic              Mem_Rdy,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [DATA_W-1:0] SRAM_DQ_out,
    output logic              SRAM_DQ_oe,
    input  logic [DATA_W-1:0] SRAM_DQ_in
`ifdef SRAM_RESP_ERR_EN
    ,
    output logic              Mem_Err
`endif
);

    localparam int unsigned MAX_WAIT = max_u(RD_WAIT, WR_WAIT);
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

    sram_resp_state_t  state_q, state_d;
    sram_pins_t        pins_q, pins_d;
    logic              rdy_q, rdy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ctr_load, ctr_dec, ctr_last_c;
    logic [CNT_W-1:0]  ctr_load_val;

    sram_wait_ctr #(.W(CNT_W)) u_wait_ctr (
        .clk      (Clk),
        .rst      (Reset),
        .load     (ctr_load),
        .load_val (ctr_load_val),
        .dec      (ctr_dec),
        .last_c   (ctr_last_c)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; completion parks in RELEASE until both strobes drop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (Mem_WE) begin
                    state_d = WR_SETUP;
                end else if (Mem_OE) begin
                    state_d = RD_ACC;
                end
            end
            RD_ACC:   if (ctr_last_c) state_d = RD_RDY;
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: if (ctr_last_c) state_d = WR_HOLD;
            RD_RDY, WR_HOLD, RELEASE: begin
                state_d = (!Mem_OE && !Mem_WE) ? IDLE : RELEASE;
            end
            default:  state_d = IDLE;
        endcase
    end

    // Pins are registered from the next state so they line up with it.
    always_comb begin
        pins_d       = PINS_INACTIVE;
        rdy_d        = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        ctr_dec      = (state_q == RD_ACC) || (state_q == WR_PULSE);
        ctr_load     = ((state_q == IDLE) && (state_d == RD_ACC)) || (state_q == WR_SETUP);
        ctr_load_val = (state_q == IDLE) ? CNT_W'(RD_WAIT) : CNT_W'(WR_WAIT);

        if ((state_q == IDLE) && (state_d != IDLE)) begin
            addr_d = ADDR;
            if (state_d == WR_SETUP) begin
                wdata_d = Data_from_CPU;
            end
        end
        if ((state_q == RD_ACC) && ctr_last_c) begin
            rdata_d = SRAM_DQ_in;
        end

        unique case (state_d)
            RD_ACC: begin
                pins_d.ce_n = 1'b0;
                pins_d.oe_n = 1'b0;
                pins_d.ub_n = 1'b0;
                pins_d.lb_n = 1'b0;
            end
            RD_RDY: rdy_d = 1'b1;
            WR_SETUP, WR_PULSE, WR_HOLD: begin
                pins_d.ce_n  = 1'b0;
                pins_d.ub_n  = 1'b0;
                pins_d.lb_n  = 1'b0;
                pins_d.dq_oe = 1'b1;
                pins_d.we_n  = (state_d != WR_PULSE);
                rdy_d        = (state_d == WR_HOLD);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pins_q  <= PINS_INACTIVE;
            rdy_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            pins_q  <= pins_d;
            rdy_q   <= rdy_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef SRAM_RESP_ERR_EN
    logic err_q, err_d;

    // Sticky: conflicting strobes in IDLE, or the active strobe dropped before Mem_Rdy.
    always_comb begin
        err_d = err_q;
        if ((state_q == IDLE) && Mem_OE && Mem_WE) begin
            err_d = 1'b1;
        end
        if (((state_q == RD_ACC) && !Mem_OE) ||
            (((state_q == WR_SETUP) || (state_q == WR_PULSE)) && !Mem_WE)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign Mem_Err = err_q;
`endif

    assign SRAM_CE_N   = pins_q.ce_n;
    assign SRAM_OE_N   = pins_q.oe_n;
    assign SRAM_WE_N   = pins_q.we_n;
    assign SRAM_UB_N   = pins_q.ub_n;
    assign SRAM_LB_N   = pins_q.lb_n;
    assign SRAM_DQ_oe  = pins_q.dq_oe;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_DQ_out = wdata_q;
    assign Data_to_CPU = rdata_q;
    assign Mem_Rdy     = rdy_q;

endmodule
